// File: rtl/renode_axi_pkg.sv
// Shared AXI4 types for the Renode AXI blocks, plus the round-robin candidate helper.
package renode_axi_pkg;

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    Address  = 2'd1,
    Data     = 2'd2,
    Response = 2'd3
  } arbiter_state_e;

  typedef logic [2:0] burst_size_t;
  typedef logic [7:0] burst_length_t;

  typedef enum logic [1:0] {
    Fixed         = 2'd0,
    Incr          = 2'd1,
    Wrap          = 2'd2,
    BurstReserved = 2'd3
  } burst_type_e;

  typedef enum logic [1:0] {
    Okay   = 2'd0,
    ExOkay = 2'd1,
    SlvErr = 2'd2,
    DecErr = 2'd3
  } response_e;

  // Manager index examined at a given offset after the round-robin pointer.
  function automatic int rr_candidate(input int pointer, input int offset, input int num);
    return (pointer + offset) % num;
  endfunction

endpackage

// File: rtl/renode_axi_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping.
module renode_axi_rr_arbiter
  import renode_axi_pkg::*;
#(
  parameter int NumManagers = 2,
  localparam int IndexWidth = $clog2(NumManagers)
) (
  input  logic [NumManagers-1:0] req,
  input  logic [IndexWidth-1:0]  pointer,
  output logic                   grant_valid,
  output logic [IndexWidth-1:0]  grant_index
);

  // Scan from the farthest offset down so the nearest requester is the last writer.
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    for (int off = NumManagers; off >= 1; off--) begin
      if (req[IndexWidth'(rr_candidate(32'(pointer), off, NumManagers))]) begin
        grant_valid = 1'b1;
        grant_index = IndexWidth'(rr_candidate(32'(pointer), off, NumManagers));
      end
    end
  end

endmodule

// File: rtl/renode_axi_interconnect_arbiter.sv
// Shares one AXI4 subordinate between NumManagers managers with independent round-robin
// read and write paths, one transaction in flight per path, manager index prefixed to IDs.
module renode_axi_interconnect_arbiter
  import renode_axi_pkg::*;
#(
  parameter int NumManagers  = 2,
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int IdWidth      = 4,
  localparam int IndexWidth  = $clog2(NumManagers),
  localparam int StrobeWidth = DataWidth / 8,
  localparam int SidWidth    = IdWidth + IndexWidth
) (
  input  logic                                     aclk,
  input  logic                                     areset,
  input  logic [NumManagers-1:0]                   m_awvalid,
  output logic [NumManagers-1:0]                   m_awready,
  input  logic [NumManagers-1:0][IdWidth-1:0]      m_awid,
  input  logic [NumManagers-1:0][AddressWidth-1:0] m_awaddr,
  input  logic [NumManagers-1:0][7:0]              m_awlen,
  input  logic [NumManagers-1:0][2:0]              m_awsize,
  input  logic [NumManagers-1:0][1:0]              m_awburst,
  input  logic [NumManagers-1:0]                   m_wvalid,
  output logic [NumManagers-1:0]                   m_wready,
  input  logic [NumManagers-1:0][DataWidth-1:0]    m_wdata,
  input  logic [NumManagers-1:0][StrobeWidth-1:0]  m_wstrb,
  input  logic [NumManagers-1:0]                   m_wlast,
  output logic [NumManagers-1:0]                   m_bvalid,
  input  logic [NumManagers-1:0]                   m_bready,
  output logic [NumManagers-1:0][IdWidth-1:0]      m_bid,
  output logic [NumManagers-1:0][1:0]              m_bresp,
  input  logic [NumManagers-1:0]                   m_arvalid,
  output logic [NumManagers-1:0]                   m_arready,
  input  logic [NumManagers-1:0][IdWidth-1:0]      m_arid,
  input  logic [NumManagers-1:0][AddressWidth-1:0] m_araddr,
  input  logic [NumManagers-1:0][7:0]              m_arlen,
  input  logic [NumManagers-1:0][2:0]              m_arsize,
  input  logic [NumManagers-1:0][1:0]              m_arburst,
  output logic [NumManagers-1:0]                   m_rvalid,
  input  logic [NumManagers-1:0]                   m_rready,
  output logic [NumManagers-1:0][IdWidth-1:0]      m_rid,
  output logic [NumManagers-1:0][DataWidth-1:0]    m_rdata,
  output logic [NumManagers-1:0][1:0]              m_rresp,
  output logic [NumManagers-1:0]                   m_rlast,
  output logic                                     s_awvalid,
  input  logic                                     s_awready,
  output logic [SidWidth-1:0]                      s_awid,
  output logic [AddressWidth-1:0]                  s_awaddr,
  output logic [7:0]                               s_awlen,
  output logic [2:0]                               s_awsize,
  output logic [1:0]                               s_awburst,
  output logic                                     s_wvalid,
  input  logic                                     s_wready,
  output logic [DataWidth-1:0]                     s_wdata,
  output logic [StrobeWidth-1:0]                   s_wstrb,
  output logic                                     s_wlast,
  input  logic                                     s_bvalid,
  output logic                                     s_bready,
  input  logic [SidWidth-1:0]                      s_bid,
  input  logic [1:0]                               s_bresp,
  output logic                                     s_arvalid,
  input  logic                                     s_arready,
  output logic [SidWidth-1:0]                      s_arid,
  output logic [AddressWidth-1:0]                  s_araddr,
  output logic [7:0]                               s_arlen,
  output logic [2:0]                               s_arsize,
  output logic [1:0]                               s_arburst,
  input  logic                                     s_rvalid,
  output logic                                     s_rready,
  input  logic [SidWidth-1:0]                      s_rid,
  input  logic [DataWidth-1:0]                     s_rdata,
  input  logic [1:0]                               s_rresp,
  input  logic                                     s_rlast,
  output logic                                     id_error,
  output logic [1:0]                               write_state,
  output logic [1:0]                               read_state
);

  // Handshakes: a beat transfers on a cycle where valid && ready; valid never waits on ready,
  // and every valid/ready is routed combinationally through the grant mux, only in its state.
  arbiter_state_e              w_state, w_state_d, r_state, r_state_d;
  logic [IndexWidth-1:0]       w_grant, w_grant_d, w_ptr, w_ptr_d;
  logic [IndexWidth-1:0]       r_grant, r_grant_d, r_ptr, r_ptr_d;
  logic                        w_arb_valid, r_arb_valid, w_id_error, r_id_error;
  logic [IndexWidth-1:0]       w_arb_index, r_arb_index;

  renode_axi_rr_arbiter #(.NumManagers(NumManagers)) u_write_arb (
    .req(m_awvalid), .pointer(w_ptr), .grant_valid(w_arb_valid), .grant_index(w_arb_index)
  );

  renode_axi_rr_arbiter #(.NumManagers(NumManagers)) u_read_arb (
    .req(m_arvalid), .pointer(r_ptr), .grant_valid(r_arb_valid), .grant_index(r_arb_index)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= Idle;
      r_state <= Idle;
      w_grant <= '0;
      r_grant <= '0;
      w_ptr   <= IndexWidth'(NumManagers - 1);
      r_ptr   <= IndexWidth'(NumManagers - 1);
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
      w_grant <= w_grant_d;
      r_grant <= r_grant_d;
      w_ptr   <= w_ptr_d;
      r_ptr   <= r_ptr_d;
    end
  end

  always_comb begin
    w_state_d  = w_state;
    w_grant_d  = w_grant;
    w_ptr_d    = w_ptr;
    w_id_error = 1'b0;
    m_awready  = '0;
    m_wready   = '0;
    m_bvalid   = '0;
    m_bid      = '0;
    m_bresp    = '0;
    s_awvalid  = 1'b0;
    s_awid     = '0;
    s_awaddr   = '0;
    s_awlen    = '0;
    s_awsize   = '0;
    s_awburst  = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;
    case (w_state)
      Idle: begin
        if (w_arb_valid) begin
          w_grant_d = w_arb_index;
          w_state_d = Address;
        end
      end
      Address: begin
        s_awvalid          = m_awvalid[w_grant];
        s_awid             = {w_grant, m_awid[w_grant]};
        s_awaddr           = m_awaddr[w_grant];
        s_awlen            = m_awlen[w_grant];
        s_awsize           = m_awsize[w_grant];
        s_awburst          = m_awburst[w_grant];
        m_awready[w_grant] = s_awready;
        if (m_awvalid[w_grant] && s_awready) w_state_d = Data;
      end
      Data: begin
        s_wvalid          = m_wvalid[w_grant];
        s_wdata           = m_wdata[w_grant];
        s_wstrb           = m_wstrb[w_grant];
        s_wlast           = m_wlast[w_grant];
        m_wready[w_grant] = s_wready;
        if (m_wvalid[w_grant] && s_wready && m_wlast[w_grant]) w_state_d = Response;
      end
      Response: begin
        m_bvalid[w_grant] = s_bvalid;
        m_bid[w_grant]    = s_bid[IdWidth-1:0];
        m_bresp[w_grant]  = s_bresp;
        s_bready          = m_bready[w_grant];
        if (s_bvalid && m_bready[w_grant]) begin
          w_state_d  = Idle;
          w_ptr_d    = w_grant;
          w_id_error = (s_bid[SidWidth-1:IdWidth] != w_grant);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    r_state_d  = r_state;
    r_grant_d  = r_grant;
    r_ptr_d    = r_ptr;
    r_id_error = 1'b0;
    m_arready  = '0;
    m_rvalid   = '0;
    m_rid      = '0;
    m_rdata    = '0;
    m_rresp    = '0;
    m_rlast    = '0;
    s_arvalid  = 1'b0;
    s_arid     = '0;
    s_araddr   = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_rready   = 1'b0;
    case (r_state)
      Idle: begin
        if (r_arb_valid) begin
          r_grant_d = r_arb_index;
          r_state_d = Address;
        end
      end
      Address: begin
        s_arvalid          = m_arvalid[r_grant];
        s_arid             = {r_grant, m_arid[r_grant]};
        s_araddr           = m_araddr[r_grant];
        s_arlen            = m_arlen[r_grant];
        s_arsize           = m_arsize[r_grant];
        s_arburst          = m_arburst[r_grant];
        m_arready[r_grant] = s_arready;
        if (m_arvalid[r_grant] && s_arready) r_state_d = Data;
      end
      Data: begin
        m_rvalid[r_grant] = s_rvalid;
        m_rid[r_grant]    = s_rid[IdWidth-1:0];
        m_rdata[r_grant]  = s_rdata;
        m_rresp[r_grant]  = s_rresp;
        m_rlast[r_grant]  = s_rlast;
        s_rready          = m_rready[r_grant];
        if (s_rvalid && m_rready[r_grant]) begin
          r_id_error = (s_rid[SidWidth-1:IdWidth] != r_grant);
          if (s_rlast) begin
            r_state_d = Idle;
            r_ptr_d   = r_grant;
          end
        end
      end
      default: ;
    endcase
  end

  assign id_error    = w_id_error | r_id_error;
  assign write_state = w_state;
  assign read_state  = r_state;

endmodule

// File: tb/tb_renode_axi_interconnect_arbiter.sv
// Directed bench for renode_axi_interconnect_arbiter: grant table plus multi-cycle corner sequences.
module tb_renode_axi_interconnect_arbiter;
  import renode_axi_pkg::*;

  localparam int NM  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 4;
  localparam int IW  = 1;
  localparam int SW  = DW / 8;

  logic aclk = 1'b0;
  logic areset;
  logic [NM-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [NM-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [NM-1:0][IDW-1:0] m_awid, m_bid, m_arid, m_rid;
  logic [NM-1:0][AW-1:0] m_awaddr, m_araddr;
  logic [NM-1:0][7:0] m_awlen, m_arlen;
  logic [NM-1:0][2:0] m_awsize, m_arsize;
  logic [NM-1:0][1:0] m_awburst, m_arburst, m_bresp, m_rresp;
  logic [NM-1:0][DW-1:0] m_wdata, m_rdata;
  logic [NM-1:0][SW-1:0] m_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, id_error;
  logic [IDW+IW-1:0] s_awid, s_bid, s_arid, s_rid;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [7:0] s_awlen, s_arlen;
  logic [2:0] s_awsize, s_arsize;
  logic [1:0] s_awburst, s_arburst, s_bresp, s_rresp, write_state, read_state;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic any_out;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic          is_write;
    logic [NM-1:0] req;
    int            grant;
    int            beats;
  } vec_t;
  vec_t vecs[13];

  renode_axi_interconnect_arbiter #(
    .NumManagers(NM), .AddressWidth(AW), .DataWidth(DW), .IdWidth(IDW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .id_error(id_error), .write_state(write_state), .read_state(read_state)
  );

  assign any_out = |{m_awready, m_wready, m_bvalid, m_bid, m_bresp, m_arready, m_rvalid, m_rid,
                     m_rdata, m_rresp, m_rlast, s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize,
                     s_awburst, s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready, s_arvalid, s_arid,
                     s_araddr, s_arlen, s_arsize, s_arburst, s_rready, id_error};

  // Clock / reset
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
    m_arvalid = '0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_rready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
  endtask

  // Write driver: address, beats of base+b, optional B stall, all checked cycle by cycle.
  task automatic write_txn(input logic [NM-1:0] req, input int g, input int beats,
                           input logic [DW-1:0] base, input int b_delay);
    logic [IW-1:0] gi;
    logic [NM-1:0] oh;
    gi = IW'(g);
    oh = '0;
    oh[gi] = 1'b1;
    for (int i = 0; i < NM; i++) begin
      m_awid[IW'(i)]    = IDW'(i + 5);
      m_awaddr[IW'(i)]  = AW'(32'h100 + i * 32'h40);
      m_awlen[IW'(i)]   = 8'(beats - 1);
      m_awsize[IW'(i)]  = 3'd2;
      m_awburst[IW'(i)] = 2'(Incr);
    end
    m_awvalid = req;
    s_awready = 1'b1;
    @(negedge aclk);
    chk("aw_latency", 64'(s_awvalid), 64'(0));
    next_cycle();
    @(negedge aclk);
    chk("aw_valid", 64'(s_awvalid), 64'(1));
    chk("aw_id", 64'(s_awid), 64'({gi, IDW'(g + 5)}));
    chk("aw_addr", 64'(s_awaddr), 64'(32'h100 + g * 32'h40));
    chk("aw_len", 64'(s_awlen), 64'(beats - 1));
    chk("aw_ready", 64'(m_awready), 64'(oh));
    next_cycle();
    m_awvalid = '0;
    s_awready = 1'b0;
    s_wready  = 1'b1;
    for (int b = 0; b < beats; b++) begin
      for (int i = 0; i < NM; i++) begin
        m_wdata[IW'(i)] = (i == g) ? base + DW'(b) : ~(base + DW'(b));
        m_wstrb[IW'(i)] = '1;
      end
      m_wvalid = oh;
      m_wlast  = (b == beats - 1) ? oh : '0;
      @(negedge aclk);
      chk("w_valid", 64'(s_wvalid), 64'(1));
      chk("w_data", 64'(s_wdata), 64'(base + DW'(b)));
      chk("w_last", 64'(s_wlast), 64'(b == beats - 1));
      chk("w_ready", 64'(m_wready), 64'(oh));
      next_cycle();
    end
    m_wvalid = '0;
    m_wlast  = '0;
    s_wready = 1'b0;
    m_bready = oh;
    for (int c = 0; c < b_delay; c++) begin
      @(negedge aclk);
      chk("b_stall", 64'({m_bvalid, write_state}), 64'({2'b00, 2'(Response)}));
      next_cycle();
    end
    s_bvalid = 1'b1;
    s_bid    = {gi, IDW'(g + 5)};
    s_bresp  = 2'(Okay);
    @(negedge aclk);
    chk("b_valid", 64'(m_bvalid), 64'(oh));
    chk("b_id", 64'(m_bid[gi]), 64'(g + 5));
    chk("b_resp", 64'(m_bresp[gi]), 64'(Okay));
    chk("b_ready", 64'(s_bready), 64'(1));
    chk("b_id_error", 64'(id_error), 64'(0));
    next_cycle();
    s_bvalid = 1'b0;
    m_bready = '0;
    @(negedge aclk);
    chk("w_done", 64'(write_state), 64'(Idle));
    next_cycle();
  endtask

  // Read driver: subordinate returns beats tagged with ret_idx as the ID index field.
  task automatic read_txn(input logic [NM-1:0] req, input int g, input int beats, input int ret_idx);
    logic [IW-1:0] gi;
    logic [NM-1:0] oh;
    logic [DW-1:0] d;
    gi = IW'(g);
    oh = '0;
    oh[gi] = 1'b1;
    for (int i = 0; i < NM; i++) begin
      m_arid[IW'(i)]    = IDW'(i + 3);
      m_araddr[IW'(i)]  = AW'(32'h1000 + i * 32'h100);
      m_arlen[IW'(i)]   = 8'(beats - 1);
      m_arsize[IW'(i)]  = 3'd2;
      m_arburst[IW'(i)] = 2'(Incr);
    end
    m_arvalid = req;
    s_arready = 1'b1;
    @(negedge aclk);
    chk("ar_latency", 64'(s_arvalid), 64'(0));
    next_cycle();
    @(negedge aclk);
    chk("ar_valid", 64'(s_arvalid), 64'(1));
    chk("ar_id", 64'(s_arid), 64'({gi, IDW'(g + 3)}));
    chk("ar_addr", 64'(s_araddr), 64'(32'h1000 + g * 32'h100));
    chk("ar_len", 64'(s_arlen), 64'(beats - 1));
    chk("ar_ready", 64'(m_arready), 64'(oh));
    next_cycle();
    m_arvalid = '0;
    s_arready = 1'b0;
    m_rready  = oh;
    for (int b = 0; b < beats; b++) begin
      d = DW'($urandom);
      s_rvalid = 1'b1;
      s_rid    = {IW'(ret_idx), IDW'(g + 3)};
      s_rdata  = d;
      s_rresp  = 2'(Okay);
      s_rlast  = (b == beats - 1);
      @(negedge aclk);
      chk("r_valid", 64'(m_rvalid), 64'(oh));
      chk("r_data", 64'(m_rdata[gi]), 64'(d));
      chk("r_last", 64'(m_rlast[gi]), 64'(b == beats - 1));
      chk("r_id", 64'(m_rid[gi]), 64'(g + 3));
      chk("r_ready", 64'(s_rready), 64'(1));
      chk("r_id_error", 64'(id_error), 64'(ret_idx != g));
      next_cycle();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = '0;
    @(negedge aclk);
    chk("r_done", 64'({read_state, id_error}), 64'({2'(Idle), 1'b0}));
    next_cycle();
  endtask

  initial begin
    // Read pointer starts at 1, write pointer is 0 after the opening m0 write.
    vecs[0]  = '{1'b0, 2'b11, 0, 1};
    vecs[1]  = '{1'b1, 2'b11, 1, 1};
    vecs[2]  = '{1'b0, 2'b11, 1, 2};
    vecs[3]  = '{1'b1, 2'b11, 0, 2};
    vecs[4]  = '{1'b0, 2'b11, 0, 1};
    vecs[5]  = '{1'b0, 2'b10, 1, 1};
    vecs[6]  = '{1'b1, 2'b10, 1, 1};
    vecs[7]  = '{1'b0, 2'b10, 1, 2};
    vecs[8]  = '{1'b1, 2'b11, 0, 1};
    vecs[9]  = '{1'b0, 2'b01, 0, 1};
    vecs[10] = '{1'b0, 2'b11, 1, 1};
    vecs[11] = '{1'b1, 2'b01, 0, 3};
    vecs[12] = '{1'b0, 2'b01, 0, 1};

    areset = 1'b1;
    clear_inputs();
    repeat (3) next_cycle();
    areset = 1'b0;
    @(negedge aclk);
    chk("reset_outputs", 64'(any_out), 64'(0));
    chk("reset_states", 64'({write_state, read_state}), 64'({2'(Idle), 2'(Idle)}));
    next_cycle();

    write_txn(2'b01, 0, 1, 32'hDEAD_BEEF, 0);

    for (int k = 0; k < 13; k++) begin
      if (vecs[k].is_write) write_txn(vecs[k].req, vecs[k].grant, vecs[k].beats, DW'(32'h1000_0000 + k * 16), 0);
      else read_txn(vecs[k].req, vecs[k].grant, vecs[k].beats, vecs[k].grant);
    end

    // m1 write burst alongside m0 read burst.
    fork
      write_txn(2'b10, 1, 4, 32'hA5A5_0000, 0);
      read_txn(2'b01, 0, 4, 0);
    join

    // Wrong index on R: still delivered to m1, id_error flagged.
    read_txn(2'b10, 1, 1, 0);
    read_txn(2'b01, 0, 1, 0);
    write_txn(2'b01, 0, 1, 32'h0BAD_F00D, 0);

    // Reset during the second beat of an m0 write burst.
    m_awvalid    = 2'b01;
    m_awid[0]    = 4'h7;
    m_awaddr[0]  = 32'h200;
    m_awlen[0]   = 8'd3;
    s_awready    = 1'b1;
    next_cycle();
    next_cycle();
    m_awvalid  = '0;
    s_awready  = 1'b0;
    s_wready   = 1'b1;
    m_wvalid   = 2'b01;
    m_wdata[0] = 32'h1111_1111;
    @(negedge aclk);
    chk("rst_beat1", 64'({s_wvalid, s_wdata}), 64'({1'b1, 32'h1111_1111}));
    next_cycle();
    m_wdata[0] = 32'h2222_2222;
    areset = 1'b1;
    @(negedge aclk);
    chk("rst_beat2_state", 64'(write_state), 64'(Data));
    next_cycle();
    areset = 1'b0;
    clear_inputs();
    @(negedge aclk);
    chk("rst_mid_outputs", 64'(any_out), 64'(0));
    chk("rst_mid_states", 64'({write_state, read_state}), 64'({2'(Idle), 2'(Idle)}));
    next_cycle();
    write_txn(2'b11, 0, 1, 32'h3333_0000, 0);
    read_txn(2'b11, 0, 1, 0);

    // Long B stall on m0 while m1 is served on the read path.
    fork
      write_txn(2'b01, 0, 1, 32'h4444_0000, 20);
      begin
        repeat (3) next_cycle();
        read_txn(2'b10, 1, 2, 1);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
